// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory port between an instruction-fetch requester
//            and a data-memory requester. Ties alternate on last_grant, the
//            memory command is held for LATENCY cycles, and a misaligned
//            access completes in one cycle with an error and no memory cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic       c_OWN_IF   = 1'b0;
  localparam logic       c_OWN_DM   = 1'b1;
  localparam logic [2:0] c_LAST_CNT = 3'(LATENCY - 1);

  state_t      r_state;
  logic        r_owner;
  logic        r_last_grant;
  logic [2:0]  r_cnt;
  logic [15:0] r_addr;
  logic        r_wr;
  logic [15:0] r_wdata;

  logic        w_access;
  logic        w_misalign;
  logic        w_last;
  logic        w_arb;
  logic        w_if_pend;
  logic        w_dm_pend;
  logic        w_grant_vld;
  logic        w_grant_dm;
  logic [15:0] w_rdata;

  assign w_access   = (r_state == S_ACCESS);
  assign w_misalign = r_addr[0];
  // A misaligned access is its own last cycle; otherwise the final count.
  assign w_last     = w_access & (w_misalign | (r_cnt == c_LAST_CNT));
  assign w_arb      = ~w_access | w_last;
  // The completing requester's still-held request is not a new request.
  assign w_if_pend  = if_req & ~(w_last & (r_owner == c_OWN_IF));
  assign w_dm_pend  = dm_req & ~(w_last & (r_owner == c_OWN_DM));
  assign w_grant_vld = w_arb & (w_if_pend | w_dm_pend);
  // On a tie the requester that did not win last time gets the grant.
  assign w_grant_dm = w_dm_pend & (~w_if_pend | (r_last_grant == c_OWN_IF));

  // Arbitration FSM: grant/latch a command, count the access, return to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= c_OWN_IF;
      r_last_grant <= c_OWN_IF;
      r_cnt        <= 3'd0;
      r_addr       <= 16'd0;
      r_wr         <= 1'b0;
      r_wdata      <= 16'd0;
    end else if (w_grant_vld) begin
      r_state      <= S_ACCESS;
      r_owner      <= w_grant_dm;
      r_last_grant <= w_grant_dm;
      r_cnt        <= 3'd0;
      r_addr       <= w_grant_dm ? dm_addr : if_addr;
      r_wr         <= w_grant_dm & dm_wr;
      r_wdata      <= w_grant_dm ? dm_wdata : 16'd0;
    end else if (w_last) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
    end else if (w_access) begin
      r_cnt        <= r_cnt + 3'd1;
    end
  end

  // Read data is forwarded only for an aligned load in its final cycle.
  assign w_rdata = (w_last & ~w_misalign & ~r_wr) ? mem_rdata : 16'd0;

  // Output decode: completion goes to the owner only, memory bus gated by mem_en.
  always_comb begin
    busy      = w_access;
    mem_en    = w_access & ~w_misalign;
    mem_wr    = mem_en & r_wr;
    mem_addr  = mem_en ? r_addr  : 16'd0;
    mem_wdata = mem_en ? r_wdata : 16'd0;
    if_done   = w_last & (r_owner == c_OWN_IF);
    dm_done   = w_last & (r_owner == c_OWN_DM);
    if_err    = if_done & w_misalign;
    dm_err    = dm_done & w_misalign;
    if_rdata  = if_done ? w_rdata : 16'd0;
    dm_rdata  = dm_done ? w_rdata : 16'd0;
    // Stall is held low while reset is asserted so every output reads zero.
    if_stall  = rst & if_req & ~if_done;
    dm_stall  = rst & dm_req & ~dm_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter (LATENCY 2, plus 1 and 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  typedef struct {
    bit          dm;
    bit          err;
    logic [15:0] rdata;
    int          cyc;
  } cpl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata, key;

  // main instance (LATENCY=2)
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, if_stall, if_err, dm_done, dm_stall, dm_err;
  logic        mem_en, mem_wr, busy;
  // LATENCY=1 instance
  logic [15:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_if_done, a_if_stall, a_if_err, a_dm_done, a_dm_stall, a_dm_err;
  logic        a_mem_en, a_mem_wr, a_busy;
  // LATENCY=8 instance
  logic [15:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_done, b_if_stall, b_if_err, b_dm_done, b_dm_stall, b_dm_err;
  logic        b_mem_en, b_mem_wr, b_busy;

  cpl_t exp_q[$];
  cpl_t obs_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_cnt, memen_cnt;
  bit   wr_seen;
  logic [15:0] wr_addr, wr_data;

  // Memory model: read data is the address scrambled by a per-test key.
  assign mem_rdata   = mem_addr ^ key;
  assign a_mem_rdata = a_mem_addr ^ key;
  assign b_mem_rdata = b_mem_addr ^ key;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .if_stall(if_stall), .if_err(if_err),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall), .dm_err(dm_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_done(a_if_done),
    .if_stall(a_if_stall), .if_err(a_if_err),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_done(a_dm_done), .dm_stall(a_dm_stall), .dm_err(a_dm_err),
    .mem_en(a_mem_en), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_arbiter #(.LATENCY(8)) u_lat8 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_done(b_if_done),
    .if_stall(b_if_stall), .if_err(b_if_err),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_done(b_dm_done), .dm_stall(b_dm_stall), .dm_err(b_dm_err),
    .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Pulse reset across a couple of cycles, leaving all requests idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: gathers completions and memory activity of the main instance.
  task automatic collect(input int n_want, input int max_cyc, input bit drop);
    int k;
    k = 0;
    obs_q.delete();
    busy_cnt = 0; memen_cnt = 0; wr_seen = 1'b0; wr_addr = '0; wr_data = '0;
    while (obs_q.size() < n_want && k < max_cyc) begin
      @(negedge clk);
      k++;
      if (busy) busy_cnt++;
      if (mem_en) memen_cnt++;
      if (mem_en && mem_wr) begin wr_seen = 1'b1; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (if_done) begin
        obs_q.push_back(cpl_t'{1'b0, if_err, if_rdata, k});
        if (drop) if_req = 1'b0;
      end
      if (dm_done) begin
        obs_q.push_back(cpl_t'{1'b1, dm_err, dm_rdata, k});
        if (drop) dm_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({if_rdata, if_done, if_stall, if_err, dm_rdata, dm_done, dm_stall, dm_err,
         mem_en, mem_wr, mem_addr, mem_wdata, busy} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b mem_en=%b, required all zero", busy, mem_en);
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, mem_en, if_done, dm_done} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b mem_en=%b, required 0", busy, mem_en);
    end
  endtask

  task automatic test_single_fetch();
    cpl_t e, o;
    @(negedge clk);
    key = 16'h0010 ^ 16'hA5A5;
    if_addr = 16'h0010; if_req = 1'b1;
    exp_q.push_back(cpl_t'{1'b0, 1'b0, 16'hA5A5, 2});
    #1;
    n_chk++;
    if (if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall: got %b, required 1", if_stall); end
    collect(1, 20, 1'b1);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL fetch_count: got %0d completions, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.dm !== e.dm || o.err !== e.err || o.rdata !== e.rdata || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL fetch_cpl: got dm=%b err=%b rdata=%h cyc=%0d, required dm=%b err=%b rdata=%h cyc=%0d",
                           o.dm, o.err, o.rdata, o.cyc, e.dm, e.err, e.rdata, e.cyc);
      end
    end
    exp_q.delete();
    n_chk++;
    if (memen_cnt != 2 || busy_cnt != 2) begin
      n_fail++; $display("FAIL fetch_mem_en: got mem_en=%0d busy=%0d cycles, required 2/2", memen_cnt, busy_cnt);
    end
  endtask

  task automatic test_priority();
    cpl_t e, o;
    do_reset();
    @(negedge clk);
    key = 16'h5A5A;
    if_addr = 16'h0020; if_req = 1'b1;
    dm_addr = 16'h0100; dm_wdata = 16'h1234; dm_wr = 1'b1; dm_req = 1'b1;
    exp_q.push_back(cpl_t'{1'b1, 1'b0, 16'h0000, 2});
    exp_q.push_back(cpl_t'{1'b0, 1'b0, 16'h0020 ^ 16'h5A5A, 4});
    collect(2, 20, 1'b1);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL prio_count: got %0d completions, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.dm !== e.dm || o.err !== e.err || o.rdata !== e.rdata || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL prio_cpl: got dm=%b err=%b rdata=%h cyc=%0d, required dm=%b err=%b rdata=%h cyc=%0d",
                           o.dm, o.err, o.rdata, o.cyc, e.dm, e.err, e.rdata, e.cyc);
      end
    end
    exp_q.delete();
    n_chk++;
    if (!wr_seen || wr_addr !== 16'h0100 || wr_data !== 16'h1234) begin
      n_fail++; $display("FAIL prio_store: got seen=%b addr=%h data=%h, required 1/0100/1234", wr_seen, wr_addr, wr_data);
    end
    n_chk++;
    if (busy_cnt != 4) begin n_fail++; $display("FAIL prio_busy: got %0d cycles, required 4", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    cpl_t e, o;
    @(negedge clk);
    key = 16'h3C3C;
    if_addr = 16'h0300; if_req = 1'b1;
    dm_addr = 16'h0200; dm_wr = 1'b0; dm_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) exp_q.push_back(cpl_t'{1'b1, 1'b0, 16'h0200 ^ 16'h3C3C, 2 * (i + 1)});
      else            exp_q.push_back(cpl_t'{1'b0, 1'b0, 16'h0300 ^ 16'h3C3C, 2 * (i + 1)});
    end
    collect(8, 40, 1'b0);
    if_req = 1'b0; dm_req = 1'b0;
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL alt_count: got %0d completions, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.dm !== e.dm || o.err !== e.err || o.rdata !== e.rdata || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL alt_cpl: got dm=%b err=%b rdata=%h cyc=%0d, required dm=%b err=%b rdata=%h cyc=%0d",
                           o.dm, o.err, o.rdata, o.cyc, e.dm, e.err, e.rdata, e.cyc);
      end
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    cpl_t e, o;
    @(negedge clk);
    dm_addr = 16'h0101; dm_wr = 1'b0; dm_req = 1'b1;
    exp_q.push_back(cpl_t'{1'b1, 1'b1, 16'h0000, 1});
    collect(1, 10, 1'b1);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL mis_count: got %0d completions, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.dm !== e.dm || o.err !== e.err || o.rdata !== e.rdata || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL mis_cpl: got dm=%b err=%b rdata=%h cyc=%0d, required dm=%b err=%b rdata=%h cyc=%0d",
                           o.dm, o.err, o.rdata, o.cyc, e.dm, e.err, e.rdata, e.cyc);
      end
    end
    exp_q.delete();
    n_chk++;
    if (memen_cnt != 0 || busy_cnt != 1) begin
      n_fail++; $display("FAIL mis_mem_en: got mem_en=%0d busy=%0d cycles, required 0/1", memen_cnt, busy_cnt);
    end
  endtask

  task automatic test_reset_abort();
    cpl_t e, o;
    bit   done_seen;
    @(negedge clk);
    dm_addr = 16'h0400; dm_wdata = 16'hBEEF; dm_wr = 1'b1; dm_req = 1'b1;
    @(negedge clk);
    n_chk++;
    if (mem_en !== 1'b1) begin n_fail++; $display("FAIL abort_started: got mem_en=%b, required 1", mem_en); end
    rst = 1'b0;
    #1;
    n_chk++;
    if ({if_rdata, if_done, if_stall, if_err, dm_rdata, dm_done, dm_stall, dm_err,
         mem_en, mem_wr, mem_addr, mem_wdata, busy} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: busy=%b mem_en=%b dm_stall=%b, required all zero", busy, mem_en, dm_stall);
    end
    done_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (dm_done) done_seen = 1'b1;
    end
    n_chk++;
    if (done_seen) begin n_fail++; $display("FAIL abort_no_done: got done=1, required 0"); end
    rst = 1'b1;
    exp_q.push_back(cpl_t'{1'b1, 1'b0, 16'h0000, 2});
    collect(1, 20, 1'b1);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL abort_count: got %0d completions, required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.dm !== e.dm || o.err !== e.err || o.rdata !== e.rdata || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL abort_cpl: got dm=%b err=%b rdata=%h cyc=%0d, required dm=%b err=%b rdata=%h cyc=%0d",
                           o.dm, o.err, o.rdata, o.cyc, e.dm, e.err, e.rdata, e.cyc);
      end
    end
    exp_q.delete();
    n_chk++;
    if (!wr_seen || wr_addr !== 16'h0400 || wr_data !== 16'hBEEF) begin
      n_fail++; $display("FAIL abort_store: got seen=%b addr=%h data=%h, required 1/0400/BEEF", wr_seen, wr_addr, wr_data);
    end
  endtask

  task automatic test_latency();
    int k1, k2, k8, b1, b2, b8;
    do_reset();
    @(negedge clk);
    if_addr = 16'h0040; if_req = 1'b1;
    k1 = 0; k2 = 0; k8 = 0; b1 = 0; b2 = 0; b8 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k1 == 0) begin if (a_busy) b1++; if (a_if_done) k1 = k; end
      if (k2 == 0) begin if (busy)   b2++; if (if_done)   k2 = k; end
      if (k8 == 0) begin if (b_busy) b8++; if (b_if_done) k8 = k; end
    end
    if_req = 1'b0;
    n_chk++;
    if (k1 != 1 || b1 != 1) begin n_fail++; $display("FAIL lat1: got done=%0d busy=%0d, required 1/1", k1, b1); end
    n_chk++;
    if (k2 != 2 || b2 != 2) begin n_fail++; $display("FAIL lat2: got done=%0d busy=%0d, required 2/2", k2, b2); end
    n_chk++;
    if (k8 != 8 || b8 != 8) begin n_fail++; $display("FAIL lat8: got done=%0d busy=%0d, required 8/8", k8, b8); end
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; key = 16'h5A5A;
    test_reset();
    test_single_fetch();
    test_priority();
    test_back_to_back();
    test_misaligned();
    test_reset_abort();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, default 2, number of cycles the memory command is held per access; legal range 1..8.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 if_req  in  1  fetch request; held with if_addr until if_done.
REQ-005 if_addr  in  16  fetch word address.
REQ-006 if_rdata  out  16  fetched instruction, valid only while if_done=1.
REQ-007 if_done  out  1  one-cycle fetch completion pulse.
REQ-008 if_stall  out  1  fetch stage must hold.
REQ-009 if_err  out  1  misaligned fetch, valid with if_done.
REQ-010 dm_req  in  1  data memory request; held with dm_wr, dm_addr, dm_wdata until dm_done.
REQ-011 dm_wr  in  1  1 = store, 0 = load.
REQ-012 dm_addr  in  16  data address.
REQ-013 dm_wdata  in  16  store data.
REQ-014 dm_rdata  out  16  load data, valid only while dm_done=1.
REQ-015 dm_done  out  1  one-cycle data completion pulse.
REQ-016 dm_stall  out  1  memory stage must hold.
REQ-017 dm_err  out  1  misaligned data access, valid with dm_done.
REQ-018 mem_en  out  1  shared memory enable.
REQ-019 mem_wr  out  1  shared memory write enable.
REQ-020 mem_addr  out  16  shared memory address.
REQ-021 mem_wdata  out  16  shared memory write data.
REQ-022 mem_rdata  in  16  shared memory read data, valid in last cycle of an access.
REQ-023 busy  out  1  high while state is ACCESS.

Function
REQ-024 FSM states: IDLE, ACCESS; registers: owner (IF/DM), last_grant (IF/DM), cnt (3 bits), latched addr/wr/wdata.
REQ-025 Arbitration in IDLE, or in the last ACCESS cycle: only one requester pending -> grant it; both pending -> grant the one not equal to last_grant.
REQ-026 A grant decided in cycle T enters ACCESS at T+1 with cnt=0 and the granted requester's command latched; last_grant updates to the granted requester.
REQ-027 In ACCESS: mem_en=1, mem_wr/mem_addr/mem_wdata from latched values; cnt increments each cycle.
REQ-028 Last ACCESS cycle is cnt==LATENCY-1: owner's done=1, owner's rdata = mem_rdata (zero for stores); access completion at T+LATENCY.
REQ-029 Back-to-back: if a request is pending in the last ACCESS cycle (excluding the completing requester's held req that cycle), the FSM stays in ACCESS with cnt=0 and the new command; otherwise it returns to IDLE.
REQ-030 Misaligned grant (latched addr bit 0 = 1): mem_en=0 for that access; ACCESS lasts exactly one cycle with owner's done=1 and err=1; no memory write occurs.
REQ-031 stall = req AND NOT done, per requester, combinational.
REQ-032 Non-owner done, err, and rdata are 0; mem_wr, mem_addr, mem_wdata are 0 when mem_en=0.
REQ-033 Request dropped before done: access still completes to memory; done pulse is discarded by the requester, no error flagged.

Reset
REQ-034 rst low: immediately state=IDLE, cnt=0, owner=IF, last_grant=IF, latched values 0; all outputs 0.
REQ-035 rst asserted mid-ACCESS aborts the access with no done pulse; after release the first tie is granted to DM.

Verification
REQ-036 LATENCY=2, if_req with if_addr=0x0010, mem_rdata=0xA5A5 -> mem_en high 2 cycles, if_done with if_rdata=0xA5A5 at T+2, if_stall high at T..T+1.
REQ-037 if_req and dm_req both at T after reset, dm_wr=1, dm_addr=0x0100, dm_wdata=0x1234 -> DM granted first, mem_wr=1 with 0x0100/0x1234, dm_done at T+2, IF granted back-to-back, if_done at T+4.
REQ-038 Both requesters continuously re-requesting for 8 accesses -> grants strictly alternate DM, IF, DM, IF...
REQ-039 dm_req load with dm_addr=0x0101 -> mem_en never high, dm_done=1 and dm_err=1 one cycle after grant.
REQ-040 rst low during cycle 1 of a store -> all outputs 0 immediately, no dm_done; after release a pending store re-executes completely.
REQ-041 LATENCY=1 and LATENCY=8 builds -> done exactly LATENCY cycles after grant decision; busy matches ACCESS cycles.
